// File: rtl/jpeg_cone_pkg.sv
// Shared types and defaults for the JPEG timing-cone result packer.
// Holds the accumulator state enum, default sizes and the default word layout.
package jpeg_cone_pkg;

    localparam int unsigned DEF_WORD_W     = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } acc_state_e;

    // Width of a bit-count field that must hold values 0..w.
    function automatic int unsigned nbits_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    typedef struct packed {
        logic [DEF_WORD_W-1:0]            data;
        logic [$clog2(DEF_WORD_W+1)-1:0]  nbits;
        logic                             last;
    } word_t;

endpackage

// File: rtl/jpeg_cone_fifo.sv
// Synchronous FIFO of packed result words.
// The pointers carry an extra wrap bit so full and empty are unambiguous.
module jpeg_cone_fifo
    import jpeg_cone_pkg::*;
#(
    parameter type         T     = word_t,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    T              mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        // Empty head reads as all-zero rather than stale storage.
        rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/jpeg_cone_result_packer.sv
// Packs single-bit cone results into words, buffers them in a FIFO and
// presents them on a valid/ready output with a popped-word counter.
module jpeg_cone_result_packer
    import jpeg_cone_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_bit,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [WORD_W-1:0]                 out_data,
    output logic [nbits_w(WORD_W)-1:0]        out_nbits,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic [CNT_W-1:0]                  word_count
);

    localparam int unsigned FILL_W = $clog2(WORD_W);
    localparam int unsigned NB_W   = nbits_w(WORD_W);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [NB_W-1:0]   nbits;
        logic              last;
    } pword_t;

    acc_state_e         state_q, state_d;
    logic [FILL_W-1:0]  fill_q;
    logic [WORD_W-1:0]  shreg_q;
    logic [CNT_W-1:0]   word_count_q;

    logic               accept;
    logic               close;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [FILL_W-1:0]  cur_fill;
    logic [FILL_W-1:0]  pos;
    logic [WORD_W-1:0]  cur_data;
    pword_t             push_word;
    pword_t             head_word;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = close ? StIdle : StAccum;
        end
    end

    // Idle always starts a fresh word regardless of register contents.
    always_comb begin
        cur_fill = (state_q == StAccum) ? fill_q : '0;
        cur_data = (state_q == StAccum) ? shreg_q : '0;
        close    = accept && ((cur_fill == FILL_W'(WORD_W - 1)) || in_last);
        pos      = LSB_FIRST ? cur_fill : (FILL_W'(WORD_W - 1) - cur_fill);
        push_word.data       = cur_data;
        push_word.data[pos]  = in_bit;
        push_word.nbits      = NB_W'(cur_fill) + NB_W'(1);
        push_word.last       = in_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q  <= '0;
            shreg_q <= '0;
        end else if (accept) begin
            if (close) begin
                fill_q  <= '0;
                shreg_q <= '0;
            end else begin
                fill_q  <= cur_fill + FILL_W'(1);
                shreg_q <= push_word.data;
            end
        end
    end

    jpeg_cone_fifo #(
        .T     (pword_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (close),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_data  = head_word.data;
    assign out_nbits = head_word.nbits;
    assign out_last  = head_word.last;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
        end else if (pop) begin
            word_count_q <= word_count_q + CNT_W'(1);
        end
    end

    assign word_count = word_count_q;

endmodule

// File: tb/tb_jpeg_cone_result_packer.sv
// Directed bench for the cone result packer: default LSB-first instance plus
// an MSB-first instance with a 4-bit word counter.
module tb_jpeg_cone_result_packer;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_bit, in_last, in_ready;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_nbits;
    logic [15:0] word_count;

    logic        b_in_valid, b_in_bit, b_in_last, b_in_ready;
    logic        b_out_valid, b_out_last, b_out_ready;
    logic [7:0]  b_out_data;
    logic [3:0]  b_out_nbits;
    logic [3:0]  b_word_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jpeg_cone_result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_nbits  (out_nbits),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    jpeg_cone_result_packer #(
        .LSB_FIRST (1'b0),
        .CNT_W     (4)
    ) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_bit     (b_in_bit),
        .in_last    (b_in_last),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_data   (b_out_data),
        .out_nbits  (b_out_nbits),
        .out_last   (b_out_last),
        .out_ready  (b_out_ready),
        .word_count (b_word_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic last);
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input logic b, input logic last);
        b_in_valid = 1'b1;
        b_in_bit   = b;
        b_in_last  = last;
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send(w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_bit = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_nbits", 32'(out_nbits), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_word_count", 32'(word_count), 32'h0);

        // 1: eight bits 1,0,1,1,0,0,1,0 LSB-first -> 0x4D
        pat = 8'h4D;
        send_byte(pat);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data", 32'(out_data), 32'h4D);
        chk("t1_nbits", 32'(out_nbits), 32'h8);
        chk("t1_last", 32'(out_last), 32'h0);

        // 2: 1,1,1 with last on the third; pops 0x4D meanwhile
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("t2_data", 32'(out_data), 32'h07);
        chk("t2_nbits", 32'(out_nbits), 32'h3);
        chk("t2_last", 32'(out_last), 32'h1);
        chk("t2_wc", 32'(word_count), 32'h1);
        send(1'b1, 1'b1);
        chk("t2_fresh_data", 32'(out_data), 32'h01);
        chk("t2_fresh_nbits", 32'(out_nbits), 32'h1);
        tick();
        chk("t2_wc_after", 32'(word_count), 32'h3);
        chk("t2_empty", 32'(out_valid), 32'h0);

        // 3: stalled consumer fills the FIFO with four words
        out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h0F);
        send_byte(8'hF0);
        chk("t3_full_in_ready", 32'(in_ready), 32'h0);
        chk("t3_head", 32'(out_data), 32'hA5);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
        tick(); tick(); tick();
        chk("t3_hold_in_ready", 32'(in_ready), 32'h0);
        chk("t3_hold_data", 32'(out_data), 32'hA5);
        chk("t3_hold_nbits", 32'(out_nbits), 32'h8);
        chk("t3_hold_wc", 32'(word_count), 32'h3);

        // 4: full with pop and offered push in the same cycle: pop only
        out_ready = 1'b1;
        tick();
        chk("t4_in_ready", 32'(in_ready), 32'h1);
        chk("t4_head", 32'(out_data), 32'h3C);
        chk("t4_wc", 32'(word_count), 32'h4);
        tick();
        in_valid = 1'b0;
        chk("t4_head2", 32'(out_data), 32'h0F);
        chk("t4_wc2", 32'(word_count), 32'h5);
        send(1'b0, 1'b0);
        chk("t4_head3", 32'(out_data), 32'hF0);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("t4_fifth_data", 32'(out_data), 32'h81);
        chk("t4_fifth_nbits", 32'(out_nbits), 32'h8);
        chk("t4_fifth_wc", 32'(word_count), 32'h7);
        tick();
        chk("t4_drained", 32'(out_valid), 32'h0);
        chk("t4_final_wc", 32'(word_count), 32'h8);

        // 5: reset with two buffered words and five partial bits
        out_ready = 1'b0;
        send_byte(8'hFF);
        send_byte(8'hFF);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_wc", 32'(word_count), 32'h0);
        chk("t5_data", 32'(out_data), 32'h0);
        chk("t5_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        send_byte(8'h02);
        chk("t5_word", 32'(out_data), 32'h02);
        chk("t5_nbits", 32'(out_nbits), 32'h8);
        tick();
        chk("t5_wc_after", 32'(word_count), 32'h1);

        // 6: MSB-first instance, then 4-bit counter wrap
        send_b(1'b1, 1'b1);
        chk("t6_data", 32'(b_out_data), 32'h80);
        chk("t6_nbits", 32'(b_out_nbits), 32'h1);
        chk("t6_last", 32'(b_out_last), 32'h1);
        tick();
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) send_b(pat[i], 1'b0);
        chk("t6_msb_word", 32'(b_out_data), 32'hB2);
        tick();
        chk("t6_wc2", 32'(b_word_count), 32'h2);
        for (int i = 0; i < 13; i++) begin
            send_b(1'b1, 1'b1);
            tick();
        end
        chk("t6_wc15", 32'(b_word_count), 32'hF);
        send_b(1'b0, 1'b1);
        chk("t6_zero_word", 32'(b_out_data), 32'h00);
        tick();
        chk("t6_wrap", 32'(b_word_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
